// File: rtl/serial_right_shifter_pkg.sv
// Shared SimpleALU definitions: shifter FSM encodings and datapath widths.
package serial_right_shifter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/serial_right_shifter_rshift1_stage.sv
// One-bit right shift with an explicit fill bit entering at the MSB.
// Kept standalone so a barrel variant can chain WIDTH copies of it.
module rshift1_stage
    import serial_right_shifter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    // Drop the LSB, bring the fill bit in at the top.
    assign dout = WIDTH'({fill, din} >> 1);

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter (logical / arithmetic), one bit position per clock.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start
//  ST_SHIFT | shifting sreg one bit per cycle until cnt reaches zero
//  ST_DONE  | result valid, done high; a new start is accepted here too
module serial_right_shifter
    import serial_right_shifter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int SHW   = SHAMT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shiftamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sreg_shr;

    rshift1_stage #(.WIDTH(WIDTH)) u_stage (
        .din  (sreg_q),
        .fill (fill_q),
        .dout (sreg_shr)
    );

    // Next-state logic: operand capture, bit stepping and result commit.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sreg_d  = data;
                    cnt_d   = shiftamt;
                    fill_d  = arith & data[WIDTH-1];
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d = sreg_shr;
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    result_d = sreg_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
